// File: rtl/aa_pack_pkg.sv
// Shared sizes and the FIFO entry layout for the byte-to-word packer.
package aa_pack_pkg;

    localparam int unsigned DEF_BYTE_W         = 8;
    localparam int unsigned DEF_BYTES_PER_WORD = 4;
    localparam int unsigned DEF_DEPTH          = 4;

    localparam int unsigned WORD_W = DEF_BYTE_W * DEF_BYTES_PER_WORD;
    localparam int unsigned CNT_W  = $clog2(DEF_BYTES_PER_WORD + 1);

    // One buffered word: packed data (first byte at bit 0) and its valid byte count.
    typedef struct packed {
        logic [0:WORD_W-1] data;
        logic [CNT_W-1:0]  nbytes;
    } word_entry_t;

endpackage

// File: rtl/aa_pack_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; async active-high reset.
module aa_pack_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (AW + 1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head reads as zero when nothing is buffered.
    assign head_data = empty ? '0 : mem[rptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= push_data;
    end

endmodule

// File: rtl/aa_word_packer.sv
// Packs consecutive input bytes into words, buffers them in a FWFT FIFO and
// supports flushing partial words; overflow is sticky until reset.
module aa_word_packer
    import aa_pack_pkg::*;
#(
    parameter int unsigned BYTE_W         = DEF_BYTE_W,
    parameter int unsigned BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int unsigned DEPTH          = DEF_DEPTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    input  logic [0:BYTE_W-1]                      in_data,
    output logic                                   in_ready,
    input  logic                                   flush,
    output logic                                   out_valid,
    output logic [0:BYTE_W*BYTES_PER_WORD-1]       out_data,
    output logic [$clog2(BYTES_PER_WORD+1)-1:0]    out_bytes,
    input  logic                                   out_ready,
    output logic                                   overflow
);

    localparam int unsigned WordW = BYTE_W * BYTES_PER_WORD;
    localparam int unsigned NbW   = $clog2(BYTES_PER_WORD + 1);
    localparam int unsigned AccW  = $clog2(BYTES_PER_WORD);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned EntW  = WordW + NbW;

    logic [0:WordW-1] acc_q, acc_d;
    logic [AccW-1:0]  acc_cnt_q, acc_cnt_d;
    logic             flush_pend_q, flush_pend_d;
    logic             overflow_q;

    logic             fifo_full, fifo_empty;
    logic [AW:0]      fifo_count;
    logic [EntW-1:0]  head;
    logic             push;
    logic [0:WordW-1] push_word;
    logic [NbW-1:0]   push_nbytes;
    logic [NbW-1:0]   filled;
    logic             accept, last_byte, has_space, flush_req;

    assign last_byte = (acc_cnt_q == AccW'(BYTES_PER_WORD - 1));
    assign has_space = (fifo_count != (AW + 1)'(DEPTH));
    assign in_ready  = !(fifo_full && (last_byte || flush_pend_q));
    assign accept    = in_valid && in_ready;
    assign flush_req = flush || flush_pend_q;

    always_comb begin
        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        flush_pend_d = flush_pend_q;
        push         = 1'b0;
        push_word    = acc_q;
        push_nbytes  = '0;
        filled       = NbW'(acc_cnt_q);

        if (accept) begin
            acc_d[acc_cnt_q*BYTE_W +: BYTE_W] = in_data;
            acc_cnt_d = acc_cnt_q + 1'b1;
            filled    = filled + 1'b1;
        end

        // A completing byte pushes exactly one word, absorbing any flush request.
        if (accept && last_byte) begin
            push         = 1'b1;
            push_word    = acc_d;
            push_nbytes  = NbW'(BYTES_PER_WORD);
            acc_d        = '0;
            acc_cnt_d    = '0;
            flush_pend_d = 1'b0;
        end else if (flush_req && (filled != '0)) begin
            if (has_space) begin
                push         = 1'b1;
                push_word    = acc_d;
                push_nbytes  = filled;
                acc_d        = '0;
                acc_cnt_d    = '0;
                flush_pend_d = 1'b0;
            end else begin
                flush_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
            if (in_valid && !in_ready) overflow_q <= 1'b1;
        end
    end

    aa_pack_fifo #(
        .WIDTH (EntW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({push_word, push_nbytes}),
        .pop       (out_valid && out_ready),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head[EntW-1:NbW];
    assign out_bytes = head[NbW-1:0];
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_aa_word_packer.sv
// Self-checking bench for aa_word_packer: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_aa_word_packer;
    import aa_pack_pkg::*;

    localparam int N = 4;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [0:7]  in_data;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [0:31] out_data;
    logic [2:0]  out_bytes;
    logic        out_ready;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: bytes waiting to form a word, buffered words, flags.
    logic [7:0]  m_acc[$];
    word_entry_t m_fifo[$];
    bit          m_pend;
    bit          m_ovf;

    aa_word_packer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_bytes (out_bytes),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic word_entry_t make_word();
        word_entry_t e;
        e = '0;
        for (int k = 0; k < m_acc.size(); k++) e.data[k*8 +: 8] = m_acc[k];
        e.nbytes = 3'(m_acc.size());
        return e;
    endfunction

    function automatic bit exp_ready();
        return !(m_fifo.size() == D && (m_acc.size() == N - 1 || m_pend));
    endfunction

    function automatic logic [37:0] exp_vec();
        word_entry_t h;
        h = '0;
        if (m_fifo.size() != 0) h = m_fifo[0];
        return {exp_ready(), m_fifo.size() != 0, h.data, h.nbytes, m_ovf};
    endfunction

    function automatic logic [37:0] obs_vec();
        return {in_ready, out_valid, out_valid ? out_data : 32'h0,
                out_valid ? out_bytes : 3'd0, overflow};
    endfunction

    task automatic model_reset();
        m_acc.delete();
        m_fifo.delete();
        m_pend = 0;
        m_ovf  = 0;
    endtask

    task automatic model_edge(bit v, logic [7:0] d, bit f, bit r);
        bit rdy, full_pre, popit;
        rdy      = exp_ready();
        full_pre = (m_fifo.size() == D);
        popit    = (m_fifo.size() != 0) && r;
        if (v && rdy) m_acc.push_back(d);
        else if (v) m_ovf = 1;
        if (popit) void'(m_fifo.pop_front());
        if (m_acc.size() == N) begin
            m_fifo.push_back(make_word());
            m_acc.delete();
            m_pend = 0;
        end else if ((f || m_pend) && m_acc.size() != 0) begin
            if (!full_pre) begin
                m_fifo.push_back(make_word());
                m_acc.delete();
                m_pend = 0;
            end else begin
                m_pend = 1;
            end
        end
    endtask

    task automatic cycle(bit v, logic [7:0] d, bit f, bit r);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        @(posedge clk);
        model_edge(v, d, f, r);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [37:0] o;
        in_valid = 0; in_data = '0; flush = 0; out_ready = 0;
        rst = 1'b1;
        model_reset();
        #2;
        o = {in_ready, out_valid, out_data, out_bytes, overflow};
        n_cmp++;
        if (o !== {1'b1, 1'b0, 32'h0, 3'd0, 1'b0}) begin
            n_bad++; $display("FAIL reset_initial: got %h want %h", o, {1'b1, 37'h0});
        end
        @(posedge clk); #1; rst = 1'b0;
        // One word buffered and two bytes in flight, then reset mid-word.
        for (int i = 0; i < 6; i++) cycle(1, 8'(8'h30 + i), 0, 0);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++; $display("FAIL reset_prefill_valid: got %b want 1", out_valid);
        end
        rst = 1'b1;
        model_reset();
        #2;
        o = {in_ready, out_valid, out_data, out_bytes, overflow};
        n_cmp++;
        if (o !== {1'b1, 1'b0, 32'h0, 3'd0, 1'b0}) begin
            n_bad++; $display("FAIL reset_midword: got %h want %h", o, {1'b1, 37'h0});
        end
        @(posedge clk); #1; rst = 1'b0;
        cycle(1, 8'hA1, 0, 1);
        cycle(1, 8'hA2, 0, 1);
        cycle(1, 8'hA3, 0, 1);
        cycle(1, 8'hA4, 0, 1);
        n_cmp++;
        if ({out_valid, out_data, out_bytes} !== {1'b1, 32'hA1A2A3A4, 3'd4}) begin
            n_bad++; $display("FAIL reset_lane0: got %b %h %0d want 1 a1a2a3a4 4",
                              out_valid, out_data, out_bytes);
        end
        cycle(0, 8'h00, 0, 1);
    endtask

    task automatic test_pack();
        logic [7:0] b [4];
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
        for (int i = 0; i < 3; i++) begin
            cycle(1, b[i], 0, 1);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++; $display("FAIL pack_early_valid[%0d]: got %b want 0", i, out_valid);
            end
        end
        cycle(1, b[3], 0, 1);
        n_cmp++;
        if ({out_valid, out_data, out_bytes} !== {1'b1, 32'h11223344, 3'd4}) begin
            n_bad++; $display("FAIL pack_word: got %b %h %0d want 1 11223344 4",
                              out_valid, out_data, out_bytes);
        end
        cycle(0, 8'h00, 0, 1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL pack_one_cycle: got %b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        cycle(1, 8'hAA, 0, 1);
        cycle(1, 8'hBB, 0, 1);
        cycle(0, 8'h00, 1, 1);
        n_cmp++;
        if ({out_valid, out_data, out_bytes} !== {1'b1, 32'hAABB0000, 3'd2}) begin
            n_bad++; $display("FAIL flush_partial: got %b %h %0d want 1 aabb0000 2",
                              out_valid, out_data, out_bytes);
        end
        cycle(0, 8'h00, 1, 1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL flush_empty_noop: got %b want 0", out_valid);
        end
        cycle(0, 8'h00, 0, 1);
        n_cmp++;
        if (obs_vec() !== exp_vec()) begin
            n_bad++; $display("FAIL flush_after: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_byte_flush();
        cycle(1, 8'h01, 0, 1);
        cycle(1, 8'h02, 0, 1);
        cycle(1, 8'h03, 0, 1);
        cycle(1, 8'h55, 1, 1);
        n_cmp++;
        if ({out_valid, out_data, out_bytes} !== {1'b1, 32'h01020355, 3'd4}) begin
            n_bad++; $display("FAIL byteflush_word: got %b %h %0d want 1 01020355 4",
                              out_valid, out_data, out_bytes);
        end
        cycle(0, 8'h00, 0, 1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL byteflush_no_extra: got %b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 19; i++) cycle(1, 8'(i + 1), 0, 0);
        n_cmp++;
        if ({in_ready, out_valid, out_data, overflow} !== {1'b0, 1'b1, 32'h01020304, 1'b0}) begin
            n_bad++; $display("FAIL bp_full: got rdy=%b v=%b %h ovf=%b want 0 1 01020304 0",
                              in_ready, out_valid, out_data, overflow);
        end
        cycle(1, 8'hEE, 0, 0);
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_bad++; $display("FAIL bp_overflow: got %b want 1", overflow);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 8'h00, 0, 1);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL bp_drain[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        cycle(0, 8'h00, 1, 1);
        n_cmp++;
        if ({out_valid, out_data, out_bytes, overflow} !== {1'b1, 32'h11121300, 3'd3, 1'b1}) begin
            n_bad++; $display("FAIL bp_tail: got %b %h %0d ovf=%b want 1 11121300 3 1",
                              out_valid, out_data, out_bytes, overflow);
        end
        cycle(0, 8'h00, 0, 1);
    endtask

    task automatic test_full_pop_push();
        pulse_reset();
        for (int i = 0; i < 4 * N; i++) cycle(1, 8'(8'h80 + i), 0, 0);
        for (int i = 0; i < 40; i++) begin
            // Send only bytes the model expects to be accepted; pop every 4th cycle.
            cycle(exp_ready(), 8'(8'hC0 + i), 0, (i % 4) == 0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL fullpp[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_bad++; $display("FAIL fullpp_no_loss: got %b want 0", overflow);
        end
    endtask

    task automatic test_random();
        bit v, f, r;
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 9) == 0);
            r = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
            cycle(v, 8'($urandom), f, r);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_flush();
        test_byte_flush();
        test_backpressure();
        test_full_pop_push();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
